// File: rtl/vga_pkg.sv
// Shared definitions for the sprite pixel stage: screen size, colours,
// bullet record, frame-update FSM states and a 1-D span hit helper.
package vga_pkg;

    localparam logic [9:0] H_RES = 10'd299;
    localparam logic [9:0] V_RES = 10'd238;

    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_SHIP   = 3'b010;
    localparam logic [2:0] COL_BULLET = 3'b110;

    localparam logic [8:0] SHIP_RST_X = 9'd141;
    localparam logic [8:0] SHIP_RST_Y = 9'd200;

    typedef struct packed {
        logic       active;
        logic [8:0] x;
        logic [8:0] y;
    } bullet_t;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_COPY = 2'd1,
        ST_DRAW = 2'd2
    } state_e;

    // Unsigned 10-bit difference: a negative offset sets bit 9 and fails the compare
    function automatic logic in_span(input logic [8:0] pos,
                                     input logic [8:0] org,
                                     input logic [4:0] len);
        logic [9:0] diff;
        diff = {1'b0, pos} - {1'b0, org};
        return (diff[9] == 1'b0) && (diff < {5'd0, len});
    endfunction

endpackage

// File: rtl/ship_sprite_rom.sv
// 16x16 1bpp player ship bitmap; bit 15 of each row is the leftmost pixel.
module ship_sprite_rom
    import vga_pkg::*;
(
    input  logic [3:0]  row_i,
    output logic [15:0] bits_o
);

    // Combinational row lookup
    always_comb begin
        bits_o = 16'h0000;
        case (row_i)
            4'd0:    bits_o = 16'h0180;
            4'd1:    bits_o = 16'h0180;
            4'd2:    bits_o = 16'h03C0;
            4'd3:    bits_o = 16'h03C0;
            4'd4:    bits_o = 16'h07E0;
            4'd5:    bits_o = 16'h07E0;
            4'd6:    bits_o = 16'h0FF0;
            4'd7:    bits_o = 16'h1FF8;
            4'd8:    bits_o = 16'h3FFC;
            4'd9:    bits_o = 16'h7FFE;
            4'd10:   bits_o = 16'hFFFF;
            4'd11:   bits_o = 16'hFFFF;
            4'd12:   bits_o = 16'hF3CF;
            4'd13:   bits_o = 16'hE187;
            4'd14:   bits_o = 16'hC003;
            4'd15:   bits_o = 16'h8001;
            default: bits_o = 16'h0000;
        endcase
    end

endmodule

// File: rtl/sprite_pixel_gen.sv
// Pixel stage behind the VGA timing generator: draws the ship and bullets with
// a 2-cycle pipeline; object positions are double-buffered and swapped at vblank exit.
module sprite_pixel_gen
    import vga_pkg::*;
#(
    parameter int N_BULLETS = 4,
    parameter int SPR_W     = 16,
    parameter int SPR_H     = 16,
    parameter int BUL_W     = 2,
    parameter int BUL_H     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] H_pos,
    input  logic [8:0] V_pos,
    input  logic       VGA_enable,
    input  logic       H_sync_in,
    input  logic       V_sync_in,
    input  logic [8:0] ship_x,
    input  logic [8:0] ship_y,
    input  logic       bul_valid,
    output logic       bul_ready,
    input  logic [2:0] bul_idx,
    input  logic [8:0] bul_x,
    input  logic [8:0] bul_y,
    input  logic       bul_active,
    output logic       R,
    output logic       G,
    output logic       B,
    output logic       H_sync_out,
    output logic       V_sync_out
);

    state_e     state_q, state_d;
    logic       vs_q;
    logic       rise_s;
    logic       copy_s;
    logic       bul_ready_q;
    logic       wr_s;

    bullet_t    shadow_q [N_BULLETS];
    bullet_t    live_q   [N_BULLETS];
    logic [8:0] ship_x_q, ship_y_q;

    logic       pix_ok_s;
    logic       ship_hit_s;
    logic       bul_hit_s;
    logic [3:0] dx_lo_s, dy_lo_s;

    logic       en1_q, hs1_q, vs1_q, ship_hit1_q, bul_hit1_q;
    logic [3:0] dx1_q, dy1_q;
    logic [15:0] rom_row_s;
    logic [2:0] rgb_d, rgb_q;
    logic       hs2_q, vs2_q;

    assign rise_s = V_sync_in & ~vs_q;
    assign wr_s   = bul_valid & bul_ready_q;

    // Frame-update FSM next state
    always_comb begin
        state_d = state_q;
        copy_s  = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (rise_s) state_d = ST_COPY;
                else        state_d = ST_WAIT;
            end
            ST_COPY: begin
                copy_s  = 1'b1;
                state_d = ST_DRAW;
            end
            ST_DRAW: begin
                if (!V_sync_in) state_d = ST_WAIT;
                else            state_d = ST_DRAW;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // FSM state, vsync edge history and registered ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_WAIT;
            vs_q        <= 1'b1;
            bul_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_q        <= V_sync_in;
            bul_ready_q <= (state_d != ST_COPY);
        end
    end

    // Shadow bullet table; out-of-range slot indices are accepted and dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_BULLETS; k++) shadow_q[k] <= '0;
        end else begin
            for (int k = 0; k < N_BULLETS; k++) begin
                if (wr_s && (bul_idx == 3'(k))) begin
                    shadow_q[k] <= '{active: bul_active, x: bul_x, y: bul_y};
                end
            end
        end
    end

    // Live object state, refreshed only during the single COPY cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ship_x_q <= SHIP_RST_X;
            ship_y_q <= SHIP_RST_Y;
            for (int k = 0; k < N_BULLETS; k++) live_q[k] <= '0;
        end else if (copy_s) begin
            ship_x_q <= ship_x;
            ship_y_q <= ship_y;
            for (int k = 0; k < N_BULLETS; k++) live_q[k] <= shadow_q[k];
        end
    end

    // Stage-1 hit tests against the live objects
    always_comb begin
        pix_ok_s   = ({1'b0, H_pos} < H_RES) && ({1'b0, V_pos} < V_RES);
        dx_lo_s    = H_pos[3:0] - ship_x_q[3:0];
        dy_lo_s    = V_pos[3:0] - ship_y_q[3:0];
        ship_hit_s = pix_ok_s
                   & in_span(H_pos, ship_x_q, 5'(SPR_W))
                   & in_span(V_pos, ship_y_q, 5'(SPR_H));
        bul_hit_s  = 1'b0;
        for (int k = 0; k < N_BULLETS; k++) begin
            bul_hit_s = bul_hit_s
                      | (pix_ok_s & live_q[k].active
                         & in_span(H_pos, live_q[k].x, 5'(BUL_W))
                         & in_span(V_pos, live_q[k].y, 5'(BUL_H)));
        end
    end

    // Stage 1 pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en1_q       <= 1'b0;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            ship_hit1_q <= 1'b0;
            bul_hit1_q  <= 1'b0;
            dx1_q       <= 4'd0;
            dy1_q       <= 4'd0;
        end else begin
            en1_q       <= VGA_enable;
            hs1_q       <= H_sync_in;
            vs1_q       <= V_sync_in;
            ship_hit1_q <= ship_hit_s;
            bul_hit1_q  <= bul_hit_s;
            dx1_q       <= dx_lo_s;
            dy1_q       <= dy_lo_s;
        end
    end

    ship_sprite_rom u_rom (
        .row_i  (dy1_q),
        .bits_o (rom_row_s)
    );

    // Stage-2 colour priority: bullet over ship over background
    always_comb begin
        rgb_d = COL_BLACK;
        if (!en1_q)                                          rgb_d = COL_BLACK;
        else if (bul_hit1_q)                                 rgb_d = COL_BULLET;
        else if (ship_hit1_q && rom_row_s[4'd15 - dx1_q])    rgb_d = COL_SHIP;
        else                                                 rgb_d = COL_BLACK;
    end

    // Stage 2 output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q <= COL_BLACK;
            hs2_q <= 1'b1;
            vs2_q <= 1'b1;
        end else begin
            rgb_q <= rgb_d;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
        end
    end

    assign bul_ready  = bul_ready_q;
    assign R          = rgb_q[2];
    assign G          = rgb_q[1];
    assign B          = rgb_q[0];
    assign H_sync_out = hs2_q;
    assign V_sync_out = vs2_q;

endmodule

// File: tb/tb_sprite_pixel_gen.sv
// Directed bench for sprite_pixel_gen: hand-computed pixel colours, frame swap,
// bullet handshake, clipping, latency and reset behaviour.
`timescale 1ns/1ps
module tb_sprite_pixel_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] H_pos, V_pos;
    logic       VGA_enable, H_sync_in, V_sync_in;
    logic [8:0] ship_x, ship_y;
    logic       bul_valid, bul_ready;
    logic [2:0] bul_idx;
    logic [8:0] bul_x, bul_y;
    logic       bul_active;
    logic       R, G, B, H_sync_out, V_sync_out;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [2:0] BLK = 3'b000;
    localparam logic [2:0] GRN = 3'b010;
    localparam logic [2:0] YEL = 3'b110;

    sprite_pixel_gen dut (
        .clk(clk), .rst(rst), .H_pos(H_pos), .V_pos(V_pos), .VGA_enable(VGA_enable),
        .H_sync_in(H_sync_in), .V_sync_in(V_sync_in), .ship_x(ship_x), .ship_y(ship_y),
        .bul_valid(bul_valid), .bul_ready(bul_ready), .bul_idx(bul_idx), .bul_x(bul_x),
        .bul_y(bul_y), .bul_active(bul_active), .R(R), .G(G), .B(B),
        .H_sync_out(H_sync_out), .V_sync_out(V_sync_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic probe(input string tag, input logic [8:0] h, input logic [8:0] v,
                         input logic en, input logic [2:0] exp);
        @(negedge clk);
        H_pos = h; V_pos = v; VGA_enable = en;
        @(posedge clk);
        @(posedge clk);
        #1 check(tag, {13'd0, R, G, B}, {13'd0, exp});
    endtask

    task automatic vblank(input string tag);
        int copies;
        copies = 0;
        @(negedge clk);
        VGA_enable = 1'b0; H_pos = 9'd0; V_pos = 9'd0; V_sync_in = 1'b0;
        repeat (3) @(negedge clk);
        V_sync_in = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (!bul_ready) copies++;
        end
        check(tag, 16'(copies), 16'd1);
    endtask

    task automatic write_bul(input string tag, input logic [2:0] idx, input logic [8:0] x,
                             input logic [8:0] y, input logic act);
        @(negedge clk);
        bul_valid = 1'b1; bul_idx = idx; bul_x = x; bul_y = y; bul_active = act;
        check(tag, {15'd0, bul_ready}, 16'd1);
        @(posedge clk);
        @(negedge clk);
        bul_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] hs_pat;
        int         low_cnt;

        rst = 1'b1; H_pos = 9'd0; V_pos = 9'd0; VGA_enable = 1'b0;
        H_sync_in = 1'b1; V_sync_in = 1'b1; ship_x = 9'd141; ship_y = 9'd200;
        bul_valid = 1'b0; bul_idx = 3'd0; bul_x = 9'd0; bul_y = 9'd0; bul_active = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_rgb",    {13'd0, R, G, B}, 16'd0);
        check("rst_hsync",  {15'd0, H_sync_out}, 16'd1);
        check("rst_vsync",  {15'd0, V_sync_out}, 16'd1);
        check("rst_ready",  {15'd0, bul_ready}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Default ship at (141,200); row dy=10 is fully lit, dy=0 only dx 7..8
        probe("ship_l",      9'd141, 9'd210, 1'b1, GRN);
        probe("ship_r",      9'd156, 9'd210, 1'b1, GRN);
        probe("ship_l_out",  9'd140, 9'd210, 1'b1, BLK);
        probe("ship_r_out",  9'd157, 9'd210, 1'b1, BLK);
        probe("ship_top_on", 9'd148, 9'd200, 1'b1, GRN);
        probe("ship_top_off",9'd141, 9'd200, 1'b1, BLK);
        probe("ship_below",  9'd148, 9'd216, 1'b1, BLK);
        probe("blank_en0",   9'd141, 9'd210, 1'b0, BLK);

        // Shadow ship move is deferred to the next frame
        ship_x = 9'd10; ship_y = 9'd20;
        probe("move_pending_new", 9'd10,  9'd30,  1'b1, BLK);
        probe("move_pending_old", 9'd141, 9'd210, 1'b1, GRN);
        vblank("copy1");
        probe("move_new",    9'd10,  9'd30,  1'b1, GRN);
        probe("move_old",    9'd141, 9'd210, 1'b1, BLK);

        // Bullet slot 1 at (50,60)
        write_bul("wr1_ready", 3'd1, 9'd50, 9'd60, 1'b1);
        probe("bul_pending", 9'd50, 9'd60, 1'b1, BLK);
        vblank("copy2");
        probe("bul_tl",      9'd50, 9'd60, 1'b1, YEL);
        probe("bul_br",      9'd51, 9'd63, 1'b1, YEL);
        probe("bul_r_out",   9'd52, 9'd60, 1'b1, BLK);
        probe("bul_b_out",   9'd50, 9'd64, 1'b1, BLK);
        probe("bul_l_out",   9'd49, 9'd60, 1'b1, BLK);

        // Clear slot 1, bullet over ship, discarded out-of-range slot
        write_bul("clr1_ready",  3'd1, 9'd50,  9'd60,  1'b0);
        write_bul("wr2_ready",   3'd2, 9'd15,  9'd30,  1'b1);
        write_bul("wr5_ready",   3'd5, 9'd100, 9'd100, 1'b1);
        probe("clr_pending", 9'd50, 9'd60, 1'b1, YEL);
        vblank("copy3");
        probe("bul_cleared", 9'd50,  9'd60,  1'b1, BLK);
        probe("bul_over_ship",9'd15, 9'd30,  1'b1, YEL);
        probe("ship_beside", 9'd17,  9'd30,  1'b1, GRN);
        probe("idx5_none",   9'd100, 9'd100, 1'b1, BLK);

        // Clipping at the bottom-right corner
        ship_x = 9'd290; ship_y = 9'd230;
        vblank("copy4");
        probe("clip_top_r",  9'd298, 9'd230, 1'b1, GRN);
        probe("clip_bot_on", 9'd293, 9'd237, 1'b1, GRN);
        probe("clip_bot_off",9'd292, 9'd237, 1'b1, BLK);
        probe("nowrap_col",  9'd0,   9'd237, 1'b1, BLK);
        probe("nowrap_row",  9'd295, 9'd2,   1'b1, BLK);

        // Exact two-cycle latency on a pixel stream
        probe("lat_pre",     9'd0,   9'd0,   1'b0, BLK);
        @(negedge clk);
        H_pos = 9'd293; V_pos = 9'd237; VGA_enable = 1'b1;
        @(posedge clk); #1 check("lat_e1", {13'd0, R, G, B}, {13'd0, BLK});
        @(negedge clk);
        H_pos = 9'd0; V_pos = 9'd0; VGA_enable = 1'b0;
        @(posedge clk); #1 check("lat_e2", {13'd0, R, G, B}, {13'd0, GRN});
        @(posedge clk); #1 check("lat_e3", {13'd0, R, G, B}, {13'd0, BLK});

        // Asynchronous reset while drawing
        ship_x = 9'd100; ship_y = 9'd100;
        probe("pre_rst",     9'd293, 9'd237, 1'b1, GRN);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_async_rgb",   {13'd0, R, G, B}, 16'd0);
        check("rst_async_ready", {15'd0, bul_ready}, 16'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        probe("rst_ship_home",   9'd141, 9'd210, 1'b1, GRN);
        probe("rst_no_copy_pix", 9'd105, 9'd110, 1'b1, BLK);
        low_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (!bul_ready) low_cnt++;
        end
        check("rst_no_copy", 16'(low_cnt), 16'd0);
        vblank("copy5");
        probe("post_rst_ship",   9'd105, 9'd110, 1'b1, GRN);
        probe("post_rst_old",    9'd141, 9'd210, 1'b1, BLK);

        // H sync delayed by exactly two clocks
        hs_pat = 8'b1011_0010;
        @(negedge clk);
        H_sync_in = hs_pat[0];
        @(posedge clk);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            H_sync_in = hs_pat[i];
            @(posedge clk);
            #1 check("hsync_delay", {15'd0, H_sync_out}, {15'd0, hs_pat[i-1]});
        end
        H_sync_in = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
